// File: rtl/freq_rom_arbiter.sv
// Round-robin arbiter sharing one registered note-to-frequency ROM among N_VOICE voices.
// Optional build macro NOTE_FOLD_EN: octave-fold out-of-range notes into 12..119 before issue.
module freq_rom_arbiter #(
    parameter int N_VOICE = 4,
    parameter int ID_W    = 2,
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [N_VOICE-1:0]          req_i,
    input  logic [N_VOICE*ADDR_W-1:0]   note_i,
    output logic [N_VOICE-1:0]          gnt_o,
    output logic                        rom_en_o,
    output logic [ADDR_W-1:0]           rom_addr_o,
    input  logic [DATA_W-1:0]           rom_data_i,
    output logic                        rsp_valid_o,
    output logic [ID_W-1:0]             rsp_id_o,
    output logic [DATA_W-1:0]           rsp_data_o,
    output logic                        rsp_bad_o
);

    localparam logic [ADDR_W-1:0] NOTE_LO = ADDR_W'(12);
    localparam logic [ADDR_W-1:0] NOTE_HI = ADDR_W'(119);
    localparam logic [ADDR_W-1:0] OCTAVE  = ADDR_W'(12);

    logic [N_VOICE-1:0] gnt_q, gnt_d;
    logic               rom_en_q, rom_en_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic [ID_W-1:0]    s1_id_q, s1_id_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic               s2_valid_q, s2_bad_q, s2_bad_d;
    logic [ID_W-1:0]    s2_id_q;
    logic               rsp_valid_q, rsp_bad_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic [DATA_W-1:0]  rsp_data_q;

    logic [ADDR_W-1:0]  notes [N_VOICE];
    logic [N_VOICE-1:0] eligible;
    logic               found;
    logic [ID_W-1:0]    win;
    logic [ID_W:0]      sum;

    function automatic logic [ADDR_W-1:0] fold_note(input logic [ADDR_W-1:0] n);
`ifdef NOTE_FOLD_EN
        if (n < NOTE_LO)      return n + OCTAVE;
        else if (n > NOTE_HI) return n - OCTAVE;
        else                  return n;
`else
        return n;
`endif
    endfunction

    always_comb begin
        for (int v = 0; v < N_VOICE; v++) begin
            notes[v] = note_i[v*ADDR_W +: ADDR_W];
        end
    end

    // The voice granted last edge is masked so its still-high req cannot win twice.
    always_comb begin
        eligible = req_i & ~gnt_q;
        found    = 1'b0;
        win      = '0;
        sum      = '0;
        for (int i = 0; i < N_VOICE; i++) begin
            sum = {1'b0, ptr_q} + (ID_W+1)'(i);
            if (sum >= (ID_W+1)'(N_VOICE)) sum = sum - (ID_W+1)'(N_VOICE);
            if (!found && eligible[sum[ID_W-1:0]]) begin
                found = 1'b1;
                win   = sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        gnt_d      = '0;
        rom_en_d   = 1'b0;
        rom_addr_d = rom_addr_q;
        s1_id_d    = s1_id_q;
        ptr_d      = ptr_q;
        if (found) begin
            gnt_d      = N_VOICE'(1) << win;
            rom_en_d   = 1'b1;
            rom_addr_d = fold_note(notes[win]);
            s1_id_d    = win;
            ptr_d      = (win == ID_W'(N_VOICE-1)) ? '0 : win + ID_W'(1);
        end
    end

    always_comb begin
`ifdef NOTE_FOLD_EN
        s2_bad_d = 1'b0;
`else
        s2_bad_d = rom_en_q && ((rom_addr_q < NOTE_LO) || (rom_addr_q > NOTE_HI));
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gnt_q       <= '0;
            rom_en_q    <= 1'b0;
            rom_addr_q  <= '0;
            s1_id_q     <= '0;
            ptr_q       <= '0;
            s2_valid_q  <= 1'b0;
            s2_id_q     <= '0;
            s2_bad_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_bad_q   <= 1'b0;
        end else begin
            gnt_q       <= gnt_d;
            rom_en_q    <= rom_en_d;
            rom_addr_q  <= rom_addr_d;
            s1_id_q     <= s1_id_d;
            ptr_q       <= ptr_d;
            s2_valid_q  <= rom_en_q;
            s2_id_q     <= s1_id_q;
            s2_bad_q    <= s2_bad_d;
            rsp_valid_q <= s2_valid_q;
            rsp_bad_q   <= s2_valid_q & s2_bad_q;
            // Response fields hold their last value between strobes.
            if (s2_valid_q) begin
                rsp_id_q   <= s2_id_q;
                rsp_data_q <= rom_data_i;
            end
        end
    end

    assign gnt_o       = gnt_q;
    assign rom_en_o    = rom_en_q;
    assign rom_addr_o  = rom_addr_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_bad_o   = rsp_bad_q;

endmodule

// File: tb/tb_freq_rom_arbiter.sv
// Self-checking bench for freq_rom_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model; also builds with NOTE_FOLD_EN defined.
module tb_freq_rom_arbiter;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = '0;
    logic [6:0]  nv [N];
    logic [27:0] note;
    logic [3:0]  gnt;
    logic        rom_en;
    logic [6:0]  rom_addr;
    logic [15:0] rom_data = '0;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_data;
    logic        rsp_bad;

    int vectors = 0;
    int errors  = 0;

    // Model state: last winner, last grant vector, the two most recent issued reads, response.
    int          m_last = N - 1;
    logic [3:0]  m_gnt = '0;
    logic [6:0]  m_addr = '0;
    logic        g1v = 1'b0, g2v = 1'b0;
    int          g1id = 0, g2id = 0;
    int          g1addr = 0, g2addr = 0;
    logic        m_rv = 1'b0, m_rbad = 1'b0;
    int          m_rid = 0, m_rdata = 0;

    always #5 clk = ~clk;

    always_comb note = {nv[3], nv[2], nv[1], nv[0]};

    freq_rom_arbiter #(.N_VOICE(4), .ID_W(2), .ADDR_W(7), .DATA_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .note_i(note),
        .gnt_o(gnt), .rom_en_o(rom_en), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
        .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_data_o(rsp_data), .rsp_bad_o(rsp_bad)
    );

    // Frequency ROM: period-style word halving each octave, 24660 at note 12, zero outside 12..119.
    function automatic int rom_fn(input int n);
        if (n < 12 || n > 119) return 0;
        if ((n - 12) % 12 == 0) return 24660 >> ((n - 12) / 12);
        return $rtoi(24660.0 / (2.0 ** ((n - 12) / 12.0)) + 0.5);
    endfunction

    function automatic int fold_fn(input int n);
`ifdef NOTE_FOLD_EN
        if (n < 12)  return n + 12;
        if (n > 119) return n - 12;
`endif
        return n;
    endfunction

    function automatic logic bad_fn(input int a);
`ifdef NOTE_FOLD_EN
        return 1'b0;
`else
        return (a < 12 || a > 119);
`endif
    endfunction

    always @(posedge clk) if (rom_en) rom_data <= 16'(rom_fn(int'(rom_addr)));

    // Advance one edge with the model updated from the current inputs; requesters
    // drop req the cycle after they are granted.
    task automatic tick();
        int best;
        if (rst) begin
            m_gnt = '0; m_last = N - 1; m_addr = '0;
            g1v = 1'b0; g2v = 1'b0;
            m_rv = 1'b0; m_rid = 0; m_rdata = 0; m_rbad = 1'b0;
        end else begin
            m_rv = g2v;
            if (g2v) begin
                m_rid = g2id; m_rdata = rom_fn(g2addr); m_rbad = bad_fn(g2addr);
            end else begin
                m_rbad = 1'b0;
            end
            g2v = g1v; g2id = g1id; g2addr = g1addr;
            best = -1;
            for (int d = 1; d <= N; d++) begin
                int v;
                v = (m_last + d) % N;
                if (best < 0 && req[v] && !m_gnt[v]) best = v;
            end
            if (best >= 0) begin
                m_gnt  = 4'(1 << best);
                m_last = best;
                g1v = 1'b1; g1id = best; g1addr = fold_fn(int'(nv[best]));
                m_addr = 7'(g1addr);
            end else begin
                m_gnt = '0;
                g1v   = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        req = req & ~m_gnt;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111;
        for (int i = 0; i < N; i++) nv[i] = 7'd60;
        tick(); tick();
        vectors++;
        if ({gnt, rom_en, rom_addr, rsp_valid, rsp_id, rsp_data, rsp_bad} !== '0) begin
            errors++;
            $display("FAIL reset_state: gnt=%b rom_en=%b addr=%0d rv=%b id=%0d data=%0d bad=%b, want all 0",
                     gnt, rom_en, rom_addr, rsp_valid, rsp_id, rsp_data, rsp_bad);
        end
        rst = 1'b0; req = '0;
    endtask

    task automatic test_single();
        do_reset();
        nv[2] = 7'd69; req = 4'b0100;
        tick();
        vectors++;
        if ({gnt, rom_en, rom_addr} !== {4'b0100, 1'b1, 7'd69}) begin
            errors++;
            $display("FAIL single_grant: gnt=%b rom_en=%b addr=%0d, want 0100 1 69", gnt, rom_en, rom_addr);
        end
        tick();
        vectors++;
        if ({gnt, rsp_valid} !== 5'b0) begin
            errors++;
            $display("FAIL single_gap: gnt=%b rsp_valid=%b, want 0000 0", gnt, rsp_valid);
        end
        tick();
        vectors++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_bad} !== {1'b1, 2'd2, 16'd916, 1'b0}) begin
            errors++;
            $display("FAIL single_rsp: v=%b id=%0d data=%0d bad=%b, want 1 2 916 0",
                     rsp_valid, rsp_id, rsp_data, rsp_bad);
        end
    endtask

    // All four voices at once with the given notes; grants and responses run in order 0..3.
    task automatic run_four(input string tag, input int n0, input int n1, input int n2, input int n3,
                            input int a0, input int a1, input int a2, input int a3,
                            input int d0, input int d1, input int d2, input int d3,
                            input logic [3:0] bad);
        int ea [4];
        int ed [4];
        ea = '{a0, a1, a2, a3};
        ed = '{d0, d1, d2, d3};
        do_reset();
        nv[0] = 7'(n0); nv[1] = 7'(n1); nv[2] = 7'(n2); nv[3] = 7'(n3);
        req = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k < 4) begin
                vectors++;
                if (gnt !== 4'(1 << k) || rom_addr !== 7'(ea[k])) begin
                    errors++;
                    $display("FAIL %s_grant%0d: gnt=%b addr=%0d, want %b %0d",
                             tag, k, gnt, rom_addr, 4'(1 << k), ea[k]);
                end
            end
            vectors++;
            if (k < 2) begin
                if (rsp_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_early%0d: rsp_valid=%b, want 0", tag, k, rsp_valid);
                end
            end else if ({rsp_valid, rsp_id, rsp_data, rsp_bad} !==
                         {1'b1, 2'(k - 2), 16'(ed[k - 2]), bad[k - 2]}) begin
                errors++;
                $display("FAIL %s_rsp%0d: v=%b id=%0d data=%0d bad=%b, want 1 %0d %0d %b",
                         tag, k - 2, rsp_valid, rsp_id, rsp_data, rsp_bad, k - 2, ed[k - 2], bad[k - 2]);
            end
        end
    endtask

    task automatic test_back_to_back();
        run_four("b2b", 24, 36, 48, 60, 24, 36, 48, 60, 12330, 6165, 3082, 1541, 4'b0000);
    endtask

    task automatic test_boundary();
`ifdef NOTE_FOLD_EN
        run_four("bound", 5, 12, 119, 125, 17, 12, 119, 113, 18474, 24660, 51, 72, 4'b0000);
`else
        run_four("bound", 5, 12, 119, 125, 5, 12, 119, 125, 0, 24660, 51, 0, 4'b1001);
`endif
    endtask

    task automatic test_alternate();
        do_reset();
        nv[0] = 7'd36; nv[3] = 7'd100; req = 4'b1001;
        tick();
        vectors++;
        if (gnt !== 4'b0001) begin
            errors++; $display("FAIL alt_g0: gnt=%b, want 0001", gnt);
        end
        tick();
        vectors++;
        if (gnt !== 4'b1000) begin
            errors++; $display("FAIL alt_g3: gnt=%b, want 1000", gnt);
        end
        req[0] = 1'b1;
        tick();
        vectors++;
        if (gnt !== 4'b0001 || {rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd0, 16'd6165}) begin
            errors++;
            $display("FAIL alt_g0b: gnt=%b v=%b id=%0d data=%0d, want 0001 1 0 6165",
                     gnt, rsp_valid, rsp_id, rsp_data);
        end
        tick();
        vectors++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_bad} !== {1'b1, 2'd3, 16'd153, 1'b0}) begin
            errors++;
            $display("FAIL alt_rsp3: v=%b id=%0d data=%0d bad=%b, want 1 3 153 0",
                     rsp_valid, rsp_id, rsp_data, rsp_bad);
        end
        tick(); tick();
    endtask

    task automatic test_reset_inflight();
        do_reset();
        nv[1] = 7'd60; req = 4'b0010;
        tick();
        vectors++;
        if (gnt !== 4'b0010) begin
            errors++; $display("FAIL rst_fl_grant: gnt=%b, want 0010", gnt);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({gnt, rom_en, rom_addr, rsp_valid, rsp_id, rsp_data, rsp_bad} !== '0) begin
            errors++;
            $display("FAIL rst_fl_clear: gnt=%b en=%b addr=%0d v=%b id=%0d data=%0d bad=%b, want all 0",
                     gnt, rom_en, rom_addr, rsp_valid, rsp_id, rsp_data, rsp_bad);
        end
        nv[0] = 7'd50; nv[3] = 7'd70; req = 4'b1001;
        tick();
        vectors++;
        if (gnt !== 4'b0001 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_fl_prio: gnt=%b rsp_valid=%b, want 0001 0", gnt, rsp_valid);
        end
        tick();
        vectors++;
        if (gnt !== 4'b1000 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_fl_next: gnt=%b rsp_valid=%b, want 1000 0", gnt, rsp_valid);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int v = 0; v < N; v++) begin
                if (!req[v] && !m_gnt[v] && $urandom_range(0, 2) == 0) begin
                    nv[v]  = 7'($urandom_range(0, 127));
                    req[v] = 1'b1;
                end
            end
            rst = ($urandom_range(0, 59) == 0);
            tick();
            vectors++;
            if (gnt !== m_gnt || rom_en !== g1v || rom_addr !== m_addr) begin
                errors++;
                $display("FAIL rand_issue c=%0d: gnt=%b en=%b addr=%0d, want %b %b %0d",
                         c, gnt, rom_en, rom_addr, m_gnt, g1v, m_addr);
            end
            vectors++;
            if ({rsp_valid, rsp_id, rsp_data, rsp_bad} !== {m_rv, 2'(m_rid), 16'(m_rdata), m_rbad}) begin
                errors++;
                $display("FAIL rand_rsp c=%0d: v=%b id=%0d data=%0d bad=%b, want %b %0d %0d %b",
                         c, rsp_valid, rsp_id, rsp_data, rsp_bad, m_rv, m_rid, m_rdata, m_rbad);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) nv[i] = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_alternate();
        test_boundary();
        test_reset_inflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/freq_rom_arbiter.md
Name: freq_rom_arbiter

Overview:
Shares the single registered note-to-frequency ROM (7-bit note address, 16-bit increment, 1-cycle read latency, zero outside notes 12..119) among N_VOICE oscillator voices. The block runs round-robin arbitration over voice requests and drives the ROM enable and address. It tracks the voice ID of each in-flight read and returns the ROM word tagged with the requesting voice's ID. It sits between the voice oscillators and the frequency ROM.

Parameters:
N_VOICE, 4, number of requesting voices (2..8)
ID_W, 2, width of voice ID (ceil(log2(N_VOICE)))
ADDR_W, 7, note/ROM address width
DATA_W, 16, ROM data width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
req  in  N_VOICE  per-voice request, level; held until granted
note  in  N_VOICE*ADDR_W  per-voice note number; voice i uses bits [i*ADDR_W +: ADDR_W]; stable while req[i] is high
gnt  out  N_VOICE  one-hot grant, one-cycle pulse, registered
rom_en  out  1  ROM read enable, registered
rom_addr  out  ADDR_W  ROM address, registered
rom_data  in  DATA_W  ROM registered output, valid the cycle after rom_en
rsp_valid  out  1  response strobe, one cycle
rsp_id  out  ID_W  voice ID of the response
rsp_data  out  DATA_W  frequency word for rsp_id
rsp_bad  out  1  note was outside the ROM's populated range (ROM returned 0)

Behaviour:
- Reset (rst=1 at an edge): gnt=0, rom_en=0, rom_addr=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_bad=0. The round-robin pointer goes to 0 (voice 0 highest priority). Both pipeline stages are cleared. In-flight reads are dropped with no rsp_valid.
- Eligibility: voice i is eligible when req[i]=1 and gnt[i]=0. Masking the currently granted voice prevents a double grant while the requester drops req.
- Requester rule: deassert req[i] in the cycle after gnt[i] is seen. A request re-asserted later is a new request.
- Arbitration: each edge, pick the first eligible voice searching from the pointer upward with wrap (N_VOICE-1 -> 0). At that edge:
  - gnt <= one-hot(winner)
  - rom_en <= 1
  - rom_addr <= note[winner] (after optional fold)
  - stage-1 id <= winner
  - pointer <= winner+1 mod N_VOICE
- No eligible voice: gnt <= 0, rom_en <= 0, rom_addr holds, pointer holds.
- Throughput: one grant per cycle maximum. Back-to-back grants to different voices are allowed.
- Pipeline:
  - Edge k: grant and rom_en registered.
  - Edge k+1: ROM registers data; stage-2 valid/id <= stage-1 valid/id.
  - Edge k+2: rsp_valid <= stage-2 valid, rsp_id <= stage-2 id, rsp_data <= rom_data, rsp_bad <= stage-2 valid & (stage-2 addr outside 12..119).
  - Latency: rsp_valid is high exactly 2 cycles after the matching gnt pulse. Responses return in grant order, so consecutive grants give consecutive responses.
- rsp_* hold their last values when rsp_valid=0, except rsp_bad, which is 0 whenever rsp_valid=0.
- Simultaneous events: reset wins over everything. A request arriving in the same cycle as another voice's grant competes at the next edge.
- Stall-free: there is no backpressure on rsp. Consumers must accept every rsp_valid pulse.

Optional Feature:
Macro NOTE_FOLD_EN.
- Defined: out-of-range notes are octave-folded before issue. Notes 0..11 become note+12 and notes 120..127 become note-12. rom_addr is therefore always in 12..119 and rsp_bad is tied to 0.
- Undefined: rom_addr = note unchanged. rsp_bad reports the out-of-range case and rsp_data is the ROM's 0.

Test Plan:
- Reset, then req[2]=1 with note2=69 -> gnt=4'b0100 for one cycle, rom_en=1, rom_addr=69. Two cycles later rsp_valid=1, rsp_id=2, rsp_data=916, rsp_bad=0.
- After reset, all four voices request at once with notes 24/36/48/60 -> grants 0,1,2,3 on consecutive cycles. rsp_valid is high 4 consecutive cycles with ids 0..3 and data 12330/6165/3082/1541.
- Voice 0 re-requests continuously (one idle cycle between requests) while voice 3 requests note 100 -> grants alternate 0,3,0. Voice 3 receives rsp_data=153.
- Boundary notes 12 and 119 -> rsp_data 24660 and 51, rsp_bad=0. Note 5 without NOTE_FOLD_EN -> rom_addr=5, rsp_data=0, rsp_bad=1. Note 5 with the macro -> rom_addr=17, rsp_data=18474, rsp_bad=0.
- Note 125 with NOTE_FOLD_EN -> rom_addr=113, rsp_data=72. Without the macro -> rsp_data=0, rsp_bad=1.
- rst asserted the cycle after gnt[1] -> no rsp_valid for that read, all outputs 0. With req[3] and req[0] both pending after reset, voice 0 is granted first.
